ring_jerky_checker: RTL and testbench

Receive-side checker for the jerky ring-counter one-hot stream. The expected stream alternates the home code (bit 0) with a spoke code (bit k), and k walks 1, 2, …, BW-1, 1, … (e.g. BW=4: 0001, 0010, 0001, 0100, 0001, 1000, 0001, 0010, …). The block samples one code per enabled cycle, decodes it to a binary index, acquires lock on the sequence, and flags and counts sequence violations. It sits at the far end of any path carrying the ring-counter output.

---
 rtl/ring_jerky_checker_if.sv | 27 ++
 rtl/ring_jerky_checker.sv | 138 +++++++++++++
 tb/tb_ring_jerky_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_jerky_checker_if.sv
// Signal bundle between a jerky ring-counter stream source and its checker.
// The master drives the code under test; the slave returns decode/lock/error status.
interface ring_jerky_checker_if #(
    parameter int BW    = 8,
    parameter int ERR_W = 8
);
    localparam int PW = $clog2(BW);

    logic             en;
    logic [BW-1:0]    in;
    logic             clr_err;
    logic [PW-1:0]    pos;
    logic             pos_vld;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, in, clr_err,
        input  pos, pos_vld, locked, err, err_cnt
    );

    modport slave (
        input  en, in, clr_err,
        output pos, pos_vld, locked, err, err_cnt
    );
endinterface

// File: rtl/ring_jerky_checker.sv
// Receive-side checker for the jerky ring-counter stream (home, spoke k, home, spoke k+1, ...):
// decodes each enabled sample, acquires lock on the sequence and counts violations seen while locked.
module ring_jerky_checker #(
    parameter int BW     = 8,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input logic                 clk,
    input logic                 rst_b,
    ring_jerky_checker_if.slave s_if
);
    localparam int PW = $clog2(BW);
    localparam int GW = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_exp_home;
    logic [PW-1:0]    r_exp_spk;
    logic [GW-1:0]    r_good_cnt;
    logic [PW-1:0]    r_pos;
    logic             r_pos_vld;
    logic             r_locked;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [PW-1:0]    w_idx;
    logic             w_legal;
    logic             w_spoke;
    logic [BW-1:0]    w_exp_code;
    logic             w_match;
    logic [GW-1:0]    w_good_inc;

    // Spoke successor: wraps from BW-1 back to 1, never to 0 (that is the home code).
    function automatic logic [PW-1:0] next_spk(input logic [PW-1:0] k);
        return (k == PW'(BW - 1)) ? PW'(1) : k + PW'(1);
    endfunction

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < BW; i++) begin
            if (s_if.in[i]) w_idx = PW'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_legal    = (s_if.in != '0) && ((s_if.in & (s_if.in - BW'(1))) == '0);
    assign w_spoke    = w_legal && (w_idx != '0);
    assign w_exp_code = r_exp_home ? BW'(1) : (BW'(1) << r_exp_spk);
    assign w_match    = (s_if.in == w_exp_code);
    assign w_good_inc = r_good_cnt + GW'(1);

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= HUNT;
            r_exp_home <= 1'b0;
            r_exp_spk  <= PW'(1);
            r_good_cnt <= '0;
            r_pos      <= '0;
            r_pos_vld  <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_err <= 1'b0;
            if (s_if.en) begin
                r_pos     <= w_legal ? w_idx : '0;
                r_pos_vld <= w_legal;
                unique case (r_state)
                    HUNT: begin
                        if (w_spoke) begin
                            r_exp_home <= 1'b1;
                            r_exp_spk  <= next_spk(w_idx);
                            r_good_cnt <= GW'(1);
                            if (LOCK_N == 1) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state  <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (w_match) begin
                            if (r_exp_home) begin
                                r_exp_home <= 1'b0;
                            end else begin
                                r_exp_home <= 1'b1;
                                r_exp_spk  <= next_spk(r_exp_spk);
                                r_good_cnt <= w_good_inc;
                                if (w_good_inc == GW'(LOCK_N)) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            if (r_exp_home) begin
                                r_exp_home <= 1'b0;
                            end else begin
                                r_exp_home <= 1'b1;
                                r_exp_spk  <= next_spk(r_exp_spk);
                            end
                        end else begin
                            // The offending sample is dropped; acquisition restarts on the next one.
                            r_err    <= 1'b1;
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            // Clear wins over a same-cycle increment and works regardless of en.
            if (s_if.clr_err) r_err_cnt <= '0;
        end
    end

    assign s_if.pos     = r_pos;
    assign s_if.pos_vld = r_pos_vld;
    assign s_if.locked  = r_locked;
    assign s_if.err     = r_err;
    assign s_if.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_ring_jerky_checker.sv
// Directed bench for ring_jerky_checker: lock acquisition, wrap, violations, saturation/clear,
// enable gating and asynchronous reset, with expected values from a small stream model.
module tb_ring_jerky_checker;
    localparam int BW     = 8;
    localparam int LOCK_N = 2;
    localparam int ERR_W  = 2;
    localparam int PW     = $clog2(BW);

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    ring_jerky_checker_if #(.BW(BW), .ERR_W(ERR_W)) m_if ();

    ring_jerky_checker #(.BW(BW), .LOCK_N(LOCK_N), .ERR_W(ERR_W)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .s_if  (m_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stream generator model: alternates home with a walking spoke 1..BW-1.
    logic g_home = 1'b1;
    int   g_spk  = 1;
    int   exp_pos = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] gen_code();
        logic [BW-1:0] one;
        one = BW'(1);
        return g_home ? one : (one << g_spk);
    endfunction

    task automatic gen_adv();
        if (g_home) begin
            g_home = 1'b0;
        end else begin
            g_home = 1'b1;
            g_spk  = (g_spk == BW - 1) ? 1 : g_spk + 1;
        end
    endtask

    task automatic gen_reset();
        g_home = 1'b1;
        g_spk  = 1;
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic [BW-1:0] code, input logic e, input logic clr);
        m_if.in      = code;
        m_if.en      = e;
        m_if.clr_err = clr;
        @(posedge clk);
        #1;
        m_if.en      = 1'b0;
        m_if.clr_err = 1'b0;
    endtask

    task automatic drive_gen();
        exp_pos = g_home ? 0 : g_spk;
        drive(gen_code(), 1'b1, 1'b0);
        gen_adv();
    endtask

    // Replace the next expected sample with an all-zero code.
    task automatic violate(input logic clr);
        exp_pos = 0;
        drive('0, 1'b1, clr);
        gen_adv();
    endtask

    task automatic relock();
        for (int k = 0; k < 8 && !m_if.locked; k++) drive_gen();
        check("relock", 32'(m_if.locked), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BW-1:0] wrong;
        m_if.en = 1'b0; m_if.in = '0; m_if.clr_err = 1'b0;
        #12;
        check("rst_pos",     32'(m_if.pos), 0);
        check("rst_pos_vld", 32'(m_if.pos_vld), 0);
        check("rst_locked",  32'(m_if.locked), 0);
        check("rst_err",     32'(m_if.err), 0);
        check("rst_err_cnt", 32'(m_if.err_cnt), 0);
        @(negedge clk) rst_b = 1'b1;

        // Clean stream 1,2,1,4: home ignored, spoke 1 acquires, lock after the 4th sample.
        drive_gen();
        check("s1_pos", 32'(m_if.pos), 0);  check("s1_vld", 32'(m_if.pos_vld), 1);
        check("s1_locked", 32'(m_if.locked), 0);
        drive_gen();
        check("s2_pos", 32'(m_if.pos), 1);  check("s2_locked", 32'(m_if.locked), 0);
        drive_gen();
        check("s3_pos", 32'(m_if.pos), 0);  check("s3_locked", 32'(m_if.locked), 0);
        drive_gen();
        check("s4_pos", 32'(m_if.pos), 2);  check("s4_locked", 32'(m_if.locked), 1);
        // Samples 5..40 include the wrap 128 -> 1 -> 2.
        for (int i = 5; i <= 40; i++) begin
            drive_gen();
            check("clean_pos", 32'(m_if.pos), 32'(exp_pos));
            check("clean_vld", 32'(m_if.pos_vld), 1);
            check("clean_locked", 32'(m_if.locked), 1);
            check("clean_err", 32'(m_if.err), 0);
        end
        check("clean_err_cnt", 32'(m_if.err_cnt), 0);

        // Corruption: 0x03 in place of the expected home (sample 41 is a home).
        drive(BW'(8'h03), 1'b1, 1'b0);
        gen_adv();
        check("corr_err", 32'(m_if.err), 1);       check("corr_err_cnt", 32'(m_if.err_cnt), 1);
        check("corr_locked", 32'(m_if.locked), 0); check("corr_vld", 32'(m_if.pos_vld), 0);
        check("corr_pos", 32'(m_if.pos), 0);
        drive_gen();
        check("corr_err_1cyc", 32'(m_if.err), 0);  check("corr_relock1", 32'(m_if.locked), 0);
        drive_gen();
        check("corr_relock2", 32'(m_if.locked), 0);
        drive_gen();
        check("corr_relock3", 32'(m_if.locked), 1);

        // Skipped spoke: the spoke two steps ahead arrives instead of the expected one.
        drive_gen();
        wrong = BW'(1) << ((g_spk + 1 == BW) ? 1 : g_spk + 1) % BW;
        if (g_spk + 2 >= BW) wrong = BW'(1) << (g_spk + 2 - (BW - 1));
        else                 wrong = BW'(1) << (g_spk + 2);
        drive(wrong, 1'b1, 1'b0);
        gen_adv();
        check("skip_err", 32'(m_if.err), 1);       check("skip_err_cnt", 32'(m_if.err_cnt), 2);
        check("skip_locked", 32'(m_if.locked), 0);
        // Had the wrong spoke been used to acquire, the next spoke would mismatch and lock fail.
        drive_gen(); check("skip_h1", 32'(m_if.locked), 0);
        drive_gen(); check("skip_s1", 32'(m_if.locked), 0);
        drive_gen(); check("skip_h2", 32'(m_if.locked), 0);
        drive_gen(); check("skip_s2", 32'(m_if.locked), 1);

        // Enable gating with garbage on the input.
        for (int i = 0; i < 5; i++) begin
            drive(BW'(8'hA5 ^ i), 1'b0, 1'b0);
            check("gate_locked", 32'(m_if.locked), 1);
            check("gate_err", 32'(m_if.err), 0);
            check("gate_pos", 32'(m_if.pos), 32'(exp_pos));
            check("gate_err_cnt", 32'(m_if.err_cnt), 2);
        end
        for (int i = 0; i < 4; i++) begin
            drive_gen();
            check("ungate_locked", 32'(m_if.locked), 1);
            check("ungate_pos", 32'(m_if.pos), 32'(exp_pos));
        end

        // Asynchronous reset while locked with err_cnt = 2.
        #3 rst_b = 1'b0;
        #1;
        check("arst_locked",  32'(m_if.locked), 0);
        check("arst_err_cnt", 32'(m_if.err_cnt), 0);
        check("arst_pos_vld", 32'(m_if.pos_vld), 0);
        check("arst_pos",     32'(m_if.pos), 0);
        @(negedge clk) rst_b = 1'b1;
        gen_reset();
        drive_gen(); check("rr_1", 32'(m_if.locked), 0);
        drive_gen(); check("rr_2", 32'(m_if.locked), 0);
        drive_gen(); check("rr_3", 32'(m_if.locked), 0);
        drive_gen(); check("rr_4", 32'(m_if.locked), 1);

        // Saturation: five violations with relocks in between; 2-bit counter stops at 3.
        for (int v = 0; v < 5; v++) begin
            relock();
            violate(1'b0);
            check("sat_err", 32'(m_if.err), 1);
            check("sat_err_cnt", 32'(m_if.err_cnt), (v + 1 > 3) ? 3 : v + 1);
        end
        relock();
        violate(1'b1);
        check("clr_err_pulse", 32'(m_if.err), 1);
        check("clr_err_cnt", 32'(m_if.err_cnt), 0);
        relock();
        violate(1'b0);
        check("pre_clr_cnt", 32'(m_if.err_cnt), 1);
        drive(BW'(8'hFF), 1'b0, 1'b1);
        check("clr_en0_cnt", 32'(m_if.err_cnt), 0);
        check("clr_en0_err", 32'(m_if.err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
